// File: rtl/box_plotter_pkg.sv
// Shared types and defaults for the box plotter: FSM states, mode encoding, screen size.
package box_plotter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDraw = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic {
        ModeBox   = 1'b0,
        ModeClear = 1'b1
    } mode_e;

    localparam int unsigned SCREEN_W_DEF = 160;
    localparam int unsigned SCREEN_H_DEF = 120;

endpackage

// File: rtl/box_plotter_raster_counter.sv
// Nested dx/dy raster scan: dx runs 0..w_lim, then wraps and bumps dy.
module raster_counter #(
    parameter int unsigned X_W = 8,
    parameter int unsigned Y_W = 7
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clr_i,
    input  logic           en_i,
    input  logic [X_W-1:0] w_lim_i,
    input  logic [Y_W-1:0] h_lim_i,
    output logic [X_W-1:0] dx_o,
    output logic [Y_W-1:0] dy_o,
    output logic           last_o
);

    logic [X_W-1:0] dx_q, dx_d;
    logic [Y_W-1:0] dy_q, dy_d;

    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (clr_i) begin
            dx_d = '0;
            dy_d = '0;
        end else if (en_i) begin
            if (dx_q == w_lim_i) begin
                dx_d = '0;
                dy_d = dy_q + 1'b1;
            end else begin
                dx_d = dx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign dx_o   = dx_q;
    assign dy_o   = dy_q;
    assign last_o = (dx_q == w_lim_i) && (dy_q == h_lim_i);

endmodule

// File: rtl/box_plotter.sv
// Box / clear-screen plotter feeding a VGA adapter write port, one pixel per clock.
// Optional macro BOX_PLOTTER_CLIP_EN suppresses plot for pixels outside the screen.
module box_plotter
    import box_plotter_pkg::*;
#(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned SZ_W     = 3,
    parameter int unsigned COLOUR_W = 3,
    parameter int unsigned SCREEN_W = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                start,
    input  logic                mode,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [SZ_W-1:0]     w_in,
    input  logic [SZ_W-1:0]     h_in,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic                ready,
    output logic                done,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot
);

    state_e              state_q, state_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [X_W-1:0]      w_q, w_d;
    logic [Y_W-1:0]      h_q, h_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;

    logic           accept;
    logic           drawing;
    logic           last;
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;

    assign accept  = start && (state_q == StIdle);
    assign drawing = (state_q == StDraw);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        w_d      = w_q;
        h_d      = h_q;
        colour_d = colour_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StDraw;
                    colour_d = colour_in;
                    if (mode == ModeClear) begin
                        x_d = '0;
                        y_d = '0;
                        w_d = X_W'(SCREEN_W - 1);
                        h_d = Y_W'(SCREEN_H - 1);
                    end else begin
                        x_d = x_in;
                        y_d = y_in;
                        w_d = X_W'(w_in);
                        h_d = Y_W'(h_in);
                    end
                end
            end
            StDraw:  if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            w_q      <= w_d;
            h_q      <= h_d;
            colour_q <= colour_d;
        end
    end

    raster_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_raster (
        .clk_i   (clock),
        .rst_ni  (resetN),
        .clr_i   (accept),
        .en_i    (drawing),
        .w_lim_i (w_q),
        .h_lim_i (h_q),
        .dx_o    (dx),
        .dy_o    (dy),
        .last_o  (last)
    );

    assign x_out      = x_q + dx;
    assign y_out      = y_q + dy;
    assign colour_out = colour_q;
    assign ready      = (state_q == StIdle);
    assign done       = (state_q == StDone);

`ifdef BOX_PLOTTER_CLIP_EN
    // Compare the carry-extended sums so coordinates that wrapped are rejected too.
    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;
    assign x_sum = {1'b0, x_q} + {1'b0, dx};
    assign y_sum = {1'b0, y_q} + {1'b0, dy};
    assign plot  = drawing && (x_sum < (X_W + 1)'(SCREEN_W)) && (y_sum < (Y_W + 1)'(SCREEN_H));
`else
    assign plot = drawing;
`endif

endmodule
